// File: rtl/aig_seq_eval.sv
// aig_seq_eval: sequential AND-inverter-graph evaluator, one node per clock
// in topological order from a loadable node table.
module aig_seq_eval #(
    parameter int N_IN = 20,
    parameter int N_OUT = 7,
    parameter int N_NODE = 512,
    localparam int VAR_W = $clog2(1 + N_IN + N_NODE),
    localparam int LIT_W = VAR_W + 1,
    localparam int NA_W = $clog2(N_NODE + 1),
    localparam int OI_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_node_we,
    input  logic [NA_W-1:0]  cfg_node_addr,
    input  logic [LIT_W-1:0] cfg_lit0,
    input  logic [LIT_W-1:0] cfg_lit1,
    input  logic             cfg_out_we,
    input  logic [OI_W-1:0]  cfg_out_idx,
    input  logic [LIT_W-1:0] cfg_out_lit,
    input  logic             cfg_num_we,
    input  logic [NA_W-1:0]  cfg_num,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic             busy,
    output logic             err
);
    localparam int NV = 1 + N_IN + N_NODE;
    localparam int AI_W = (N_NODE > 1) ? $clog2(N_NODE) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

    state_t             state_q, state_d;
    logic [LIT_W-1:0]   lit0_mem [N_NODE];
    logic [LIT_W-1:0]   lit1_mem [N_NODE];
    logic [LIT_W-1:0]   out_lit_q [N_OUT];
    logic [LIT_W-1:0]   out_lit_d [N_OUT];
    logic [NA_W-1:0]    num_q, num_d, k_q, k_d;
    logic [NV-1:0]      vals_q, vals_d;
    logic [N_OUT-1:0]   out_data_q, out_data_d, out_bad;
    logic               err_q, err_d;
    logic               idle, accept, last, enter_out, num_ok, cfg_any;
    logic               bad0, bad1, opnd0, opnd1;
    logic [VAR_W-1:0]   cur_var, out_lim;
    logic [LIT_W-1:0]   l0, l1;

    function automatic logic lit_val(input logic [NV-1:0] v, input logic [LIT_W-1:0] l);
        return v[l[LIT_W-1:1]] ^ l[0];
    endfunction

    assign idle      = state_q == IDLE;
    assign accept    = in_valid && in_ready;
    assign cfg_any   = cfg_node_we || cfg_out_we || cfg_num_we;
    assign num_ok    = cfg_num <= NA_W'(N_NODE);
    assign num_d     = (idle && cfg_num_we && num_ok) ? cfg_num : num_q;
    assign last      = NA_W'(k_q + 1'b1) == num_q;
    assign enter_out = (accept && num_d == '0) || (state_q == EVAL && last);
    assign cur_var   = VAR_W'(N_IN + 1) + VAR_W'(k_q);
    assign l0        = lit0_mem[k_q[AI_W-1:0]];
    assign l1        = lit1_mem[k_q[AI_W-1:0]];
    // cur_var never exceeds N_IN+N_NODE, so this also rejects out-of-range vars
    assign bad0      = l0[LIT_W-1:1] >= cur_var;
    assign bad1      = l1[LIT_W-1:1] >= cur_var;
    assign opnd0     = !bad0 && lit_val(vals_q, l0);
    assign opnd1     = !bad1 && lit_val(vals_q, l1);
    assign out_lim   = VAR_W'(N_IN) + VAR_W'(num_d);

    for (genvar g = 0; g < N_OUT; g++) begin : g_obad
        assign out_bad[g] = out_lit_d[g][LIT_W-1:1] > out_lim;
    end

    always_ff @(posedge clk) begin
        if (idle && cfg_node_we && cfg_node_addr < NA_W'(N_NODE)) begin
            lit0_mem[cfg_node_addr[AI_W-1:0]] <= cfg_lit0;
            lit1_mem[cfg_node_addr[AI_W-1:0]] <= cfg_lit1;
        end
    end

    always_comb begin
        out_lit_d = out_lit_q;
        if (idle && cfg_out_we && {1'b0, cfg_out_idx} < (OI_W + 1)'(N_OUT)) out_lit_d[cfg_out_idx] = cfg_out_lit;
    end

    always_comb begin
        err_d = err_q || (cfg_any && !idle) || (idle && cfg_num_we && !num_ok);
        k_d = k_q;
        vals_d = vals_q;
        out_data_d = out_data_q;
        if (accept) begin
            vals_d[N_IN:1] = in_data;
            k_d = '0;
        end
        if (state_q == EVAL) begin
            err_d = err_d || bad0 || bad1;
            vals_d[cur_var] = opnd0 && opnd1;
            k_d = k_q + 1'b1;
        end
        // sample from vals_d so the node finishing this cycle is visible
        if (enter_out) begin
            err_d = err_d || (|out_bad);
            for (int j = 0; j < N_OUT; j++) out_data_d[j] = !out_bad[j] && lit_val(vals_d, out_lit_d[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= '0;
            k_q <= '0;
            vals_q <= '0;
            out_data_q <= '0;
            err_q <= 1'b0;
            out_lit_q <= '{default: '0};
        end else begin
            num_q <= num_d;
            k_q <= k_d;
            vals_q <= vals_d;
            out_data_q <= out_data_d;
            err_q <= err_d;
            out_lit_q <= out_lit_d;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !accept ? IDLE : (num_d == '0) ? OUT : EVAL;
            EVAL:    state_d = last ? OUT : EVAL;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = idle && !rst;
        out_valid = state_q == OUT;
        busy = !idle;
        out_data = out_data_q;
        err = err_q;
    end
endmodule
